udma_stream_tx_arbiter: RTL and testbench
=========================================

// Module: udma_stream_tx_arbiter
// PURPOSE
//  Shares one uDMA TX channel (L2 read port: req/gnt/addr/datasize, then valid/data/ready) between
//  NB_STREAMS stream-unit requesters. Round-robin, lock-until-grant request arbitration. An
//  in-order ID FIFO routes each returned read word to the requester that issued it.
//  Sits between the stream units' tx_ch_* ports and the uDMA core TX channel mux.
// PARAMETERS
//  NB_STREAMS      4   number of requesters, >=2
//  L2_AWIDTH_NOAL  16  L2 address width
//  DATA_WIDTH      32  read data width
//  MAX_OUTST       4   max granted-but-not-returned reads (ID FIFO depth), power of 2, >=2
// PORTS
//  clk_i           in   1                  clock
//  rst_i           in   1                  synchronous reset, active-high
//  clr_i           in   1                  synchronous flush (same effect as rst_i)
//  req_i           in   NB_STREAMS         per-requester read request
//  addr_i          in   NB_STREAMS*AW      packed per-requester address, [k*AW +: AW]
//  datasize_i      in   NB_STREAMS*2       packed per-requester datasize
//  gnt_o           out  NB_STREAMS         per-requester grant
//  valid_o         out  NB_STREAMS         per-requester read-data valid
//  data_o          out  DATA_WIDTH         read data, broadcast to all requesters
//  ready_i         in   NB_STREAMS         per-requester read-data ready
//  tx_ch_req_o     out  1                  shared channel request
//  tx_ch_addr_o    out  AW                 address of selected requester
//  tx_ch_datasize_o out 2                  datasize of selected requester
//  tx_ch_gnt_i     in   1                  shared channel grant
//  tx_ch_valid_i   in   1                  shared channel read data valid
//  tx_ch_data_i    in   DATA_WIDTH         shared channel read data
//  tx_ch_ready_o   out  1                  shared channel read data ready
//  err_o           out  1                  sticky: response received with no outstanding read
// BEHAVIOUR
//  - Reset/clr: RR pointer=0, lock cleared, ID FIFO empty, outstanding count=0, err_o=0.
//    All outputs then 0 (tx_ch_req_o, gnt_o, valid_o, tx_ch_ready_o) until a request arrives.
//  - Selection: if not locked, pick the first req_i[k] set scanning from RR pointer upward,
//    wrapping at NB_STREAMS. tx_ch_req_o = any req & FIFO not full. addr/datasize mux is
//    combinational. Zero-cycle request path.
//  - Lock: tx_ch_req_o high without tx_ch_gnt_i -> selection is registered and held until
//    the grant. Requesters must hold req_i until gnt_o. The lock survives other requests arriving.
//  - Grant: gnt_o[sel] = tx_ch_gnt_i & tx_ch_req_o, all other bits 0. On grant: push sel into
//    the ID FIFO, RR pointer <= (sel+1) mod NB_STREAMS, lock cleared.
//  - Full: count==MAX_OUTST -> tx_ch_req_o=0, no grant, lock and pointer frozen.
//  - Response: head = FIFO head ID. valid_o[head] = tx_ch_valid_i & !empty.
//    tx_ch_ready_o = ready_i[head] & !empty. Pop on tx_ch_valid_i & tx_ch_ready_o.
//    data_o = tx_ch_data_i combinationally.
//  - Empty with tx_ch_valid_i: tx_ch_ready_o=1 (word dropped), valid_o=0, err_o<=1 (sticky until
//    rst/clr).
//  - Simultaneous push+pop: count unchanged, both pointers advance. A push in the same cycle
//    as a pop at full is still blocked (full is evaluated on the registered count).
//  - rst_i/clr_i in the same cycle as a grant or pop: the flush wins and nothing is recorded.
//    A flush mid-transfer drops the routing of in-flight reads. Later responses raise err_o.
//  - Pointers are log2(MAX_OUTST) bits and wrap naturally. The count is log2(MAX_OUTST)+1 bits.
// CONFIGURATION
//  UDMA_STREAM_ARB_PRIO_EN defined: requester 0 has fixed top priority. When unlocked and
//  req_i[0]=1, selects 0 regardless of RR pointer. Other requesters use RR among 1..N-1.
//  Granting 0 does not move the RR pointer.
//  Undefined: pure round-robin over all requesters as above.
// TESTING
//  1 reset, req_i=4'b0101 held -> grants 0,2,0,2 on consecutive gnt_i=1 cycles; responses go
//    to valid_o 0,2,0,2 in order
//  2 req_i[1]=1, gnt_i=0 for 3 cycles, then req_i[3] rises -> tx_ch_addr_o stays addr 1; grant
//    to 1 first, then to 3
//  3 gnt_i=1 always, valid_i=0, MAX_OUTST=4 -> 4 grants, then tx_ch_req_o=0. One valid&ready
//    -> one more grant the next cycle
//  4 head=2, ready_i[2]=0, valid_i=1 -> tx_ch_ready_o=0, FIFO held; ready_i[2]=1 -> pop,
//    data_o=data_i
//  5 valid_i=1 with FIFO empty -> tx_ch_ready_o=1, valid_o=0, err_o=1 next cycle; clr_i -> err_o=0
//  6 PRIO_EN, req_i=4'b1011 all held -> grant order 0,0,0 while req_i[0] stays high;
//    drop req_i[0] -> 1,3,1

Source files
------------

// File: rtl/udma_stream_tx_arbiter.sv
// ---------------------------------------------------------------------------------------------
// udma_stream_tx_arbiter
//
// Purpose:
//   Shares one uDMA TX channel (L2 read port: req/gnt/addr/datasize request phase, then
//   valid/data/ready response phase) between NB_STREAMS stream-unit requesters.
//   Requests are arbitrated round-robin. A selection that is presented but not granted is
//   locked until the grant arrives. Each grant pushes the winner's index into an in-order ID
//   FIFO. The FIFO head routes each returned read word back to the requester that issued it.
//
// Configuration:
//   UDMA_STREAM_ARB_PRIO_EN (define) : requester 0 gets fixed top priority. The remaining
//   requesters share round-robin among 1..NB_STREAMS-1. Granting 0 leaves the RR pointer alone.
//   Undefined (default)              : pure round-robin over all requesters.
//
// Ports:
//   clk_i, rst_i, clr_i          clock, sync active-high reset, sync flush (same effect)
//   req_i/addr_i/datasize_i      per-requester request side (addr/datasize packed per index)
//   gnt_o                        per-requester grant (one-hot or zero)
//   valid_o/ready_i, data_o      per-requester response side, data broadcast
//   tx_ch_req_o/addr_o/datasize_o, tx_ch_gnt_i     shared channel request phase
//   tx_ch_valid_i/data_i, tx_ch_ready_o            shared channel response phase
//   err_o                        sticky: response seen with no outstanding read
// ---------------------------------------------------------------------------------------------
module udma_stream_tx_arbiter #(
  parameter int unsigned NB_STREAMS     = 4,
  parameter int unsigned L2_AWIDTH_NOAL = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_OUTST      = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clr_i,

  input  logic [NB_STREAMS-1:0]                req_i,
  input  logic [NB_STREAMS*L2_AWIDTH_NOAL-1:0] addr_i,
  input  logic [NB_STREAMS*2-1:0]              datasize_i,
  output logic [NB_STREAMS-1:0]                gnt_o,
  output logic [NB_STREAMS-1:0]                valid_o,
  output logic [DATA_WIDTH-1:0]                data_o,
  input  logic [NB_STREAMS-1:0]                ready_i,

  output logic                                 tx_ch_req_o,
  output logic [L2_AWIDTH_NOAL-1:0]            tx_ch_addr_o,
  output logic [1:0]                           tx_ch_datasize_o,
  input  logic                                 tx_ch_gnt_i,
  input  logic                                 tx_ch_valid_i,
  input  logic [DATA_WIDTH-1:0]                tx_ch_data_i,
  output logic                                 tx_ch_ready_o,

  output logic                                 err_o
);

  localparam int unsigned ID_W  = $clog2(NB_STREAMS);
  localparam int unsigned PTR_W = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned AW    = L2_AWIDTH_NOAL;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_locked;
  logic [ID_W-1:0]  r_lock_sel;
  logic [ID_W-1:0]  r_fifo [MAX_OUTST];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  // ------------------------------------------------------------------
  // Combinational signals
  // ------------------------------------------------------------------
  logic                  w_flush;
  logic [NB_STREAMS-1:0] w_rr_req;
  logic                  w_prio_hit;
  logic                  w_move_ptr;
  logic [ID_W-1:0]       w_rr_sel;
  logic                  w_rr_hit;
  logic [ID_W-1:0]       w_free_sel;
  logic [ID_W-1:0]       w_sel;
  logic [ID_W-1:0]       w_next_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_grant;
  logic                  w_push;
  logic                  w_pop;
  logic [ID_W-1:0]       w_head;

  assign w_flush = rst_i | clr_i;

`ifdef UDMA_STREAM_ARB_PRIO_EN
  // Requester 0 bypasses the round-robin scan entirely.
  assign w_rr_req   = {req_i[NB_STREAMS-1:1], 1'b0};
  assign w_prio_hit = req_i[0];
  // Index 0 can only be selected through the priority path, so a grant to 0 never rotates.
  assign w_move_ptr = (w_sel != '0);
`else
  assign w_rr_req   = req_i;
  assign w_prio_hit = 1'b0;
  assign w_move_ptr = 1'b1;
`endif

  // First request at or above the RR pointer, wrapping at NB_STREAMS.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    w_rr_sel = '0;
    w_rr_hit = 1'b0;
    for (int unsigned i = 0; i < NB_STREAMS; i++) begin
      idx = 32'(r_rr_ptr) + i;
      if (idx >= NB_STREAMS) begin
        idx = idx - NB_STREAMS;
      end
      if (!w_rr_hit && w_rr_req[ID_W'(idx)]) begin
        w_rr_hit = 1'b1;
        w_rr_sel = ID_W'(idx);
      end
    end
  end

  assign w_free_sel = w_prio_hit ? '0 : w_rr_sel;
  // A pending ungranted selection is held even if a better-placed request appears.
  assign w_sel      = r_locked ? r_lock_sel : w_free_sel;
  assign w_next_ptr = (w_sel == ID_W'(NB_STREAMS - 1)) ? '0 : w_sel + 1'b1;

  // Full/empty come from the registered count, so a pop cannot free a slot in the same cycle.
  assign w_full  = (r_count == CNT_W'(MAX_OUTST));
  assign w_empty = (r_count == '0);

  // ------------------------------------------------------------------
  // Request phase
  // ------------------------------------------------------------------
  assign tx_ch_req_o      = (|req_i) & ~w_full;
  assign tx_ch_addr_o     = addr_i[32'(w_sel)*AW +: AW];
  assign tx_ch_datasize_o = datasize_i[32'(w_sel)*2 +: 2];
  assign w_grant          = tx_ch_req_o & tx_ch_gnt_i;
  assign w_push           = w_grant;

  // ------------------------------------------------------------------
  // Response phase
  // ------------------------------------------------------------------
  assign w_head = r_fifo[r_rd_ptr];
  // With nothing outstanding the word is accepted and dropped so the channel cannot stall.
  assign tx_ch_ready_o = w_empty ? tx_ch_valid_i : ready_i[w_head];
  assign w_pop         = tx_ch_valid_i & tx_ch_ready_o & ~w_empty;
  assign data_o        = tx_ch_data_i;
  assign err_o         = r_err;

  always_comb begin
    gnt_o          = '0;
    valid_o        = '0;
    gnt_o[w_sel]   = w_grant;
    valid_o[w_head] = tx_ch_valid_i & ~w_empty;
  end

  // ------------------------------------------------------------------
  // Arbitration and bookkeeping registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_flush) begin
      r_rr_ptr   <= '0;
      r_locked   <= 1'b0;
      r_lock_sel <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_locked <= 1'b0;
        if (w_move_ptr) begin
          r_rr_ptr <= w_next_ptr;
        end
      end else if (tx_ch_req_o) begin
        r_locked   <= 1'b1;
        r_lock_sel <= w_sel;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end

      if (tx_ch_valid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  // ID storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (w_push && !w_flush) begin
      r_fifo[r_wr_ptr] <= w_sel;
    end
  end

endmodule

// File: tb/tb_udma_stream_tx_arbiter.sv
module tb_udma_stream_tx_arbiter;

  localparam int unsigned NB = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             clr_i;
  logic [NB-1:0]    req_i;
  logic [NB*AW-1:0] addr_i;
  logic [NB*2-1:0]  datasize_i;
  logic [NB-1:0]    gnt_o;
  logic [NB-1:0]    valid_o;
  logic [DW-1:0]    data_o;
  logic [NB-1:0]    ready_i;
  logic             tx_ch_req_o;
  logic [AW-1:0]    tx_ch_addr_o;
  logic [1:0]       tx_ch_datasize_o;
  logic             tx_ch_gnt_i;
  logic             tx_ch_valid_i;
  logic [DW-1:0]    tx_ch_data_i;
  logic             tx_ch_ready_o;
  logic             err_o;

  int n_vec     = 0;
  int n_miscmp  = 0;

  udma_stream_tx_arbiter #(
    .NB_STREAMS     (NB),
    .L2_AWIDTH_NOAL (AW),
    .DATA_WIDTH     (DW),
    .MAX_OUTST      (MO)
  ) u_dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clr_i            (clr_i),
    .req_i            (req_i),
    .addr_i           (addr_i),
    .datasize_i       (datasize_i),
    .gnt_o            (gnt_o),
    .valid_o          (valid_o),
    .data_o           (data_o),
    .ready_i          (ready_i),
    .tx_ch_req_o      (tx_ch_req_o),
    .tx_ch_addr_o     (tx_ch_addr_o),
    .tx_ch_datasize_o (tx_ch_datasize_o),
    .tx_ch_gnt_i      (tx_ch_gnt_i),
    .tx_ch_valid_i    (tx_ch_valid_i),
    .tx_ch_data_i     (tx_ch_data_i),
    .tx_ch_ready_o    (tx_ch_ready_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  logic [3:0]  exp_g [4];
  logic [15:0] exp_a [4];

  initial begin
    rst_i         = 1'b1;
    clr_i         = 1'b0;
    req_i         = '0;
    ready_i       = '0;
    tx_ch_gnt_i   = 1'b0;
    tx_ch_valid_i = 1'b0;
    tx_ch_data_i  = '0;
    for (int k = 0; k < NB; k++) begin
      addr_i[k*AW +: AW]   = 16'hA000 + 16'(k);
      datasize_i[k*2 +: 2] = 2'(k);
    end
    next_cyc();
    next_cyc();
    rst_i = 1'b0;

    // Reset state
    mid();
    check_eq("rst_req", 32'(tx_ch_req_o), 32'd0);
    check_eq("rst_gnt", 32'(gnt_o), 32'd0);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_ready", 32'(tx_ch_ready_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    next_cyc();

    // 1: req 0101 held, grants alternate 0,2,0,2; responses routed in order
    exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    exp_a = '{16'hA000, 16'hA002, 16'hA000, 16'hA002};
    req_i       = 4'b0101;
    tx_ch_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check_eq("t1_gnt", 32'(gnt_o), 32'(exp_g[i]));
      check_eq("t1_addr", 32'(tx_ch_addr_o), 32'(exp_a[i]));
      if (i == 1) check_eq("t1_dsize", 32'(tx_ch_datasize_o), 32'd2);
      next_cyc();
    end
    req_i         = '0;
    tx_ch_gnt_i   = 1'b0;
    tx_ch_valid_i = 1'b1;
    ready_i       = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tx_ch_data_i = 32'hD000_0000 + 32'(i);
      mid();
      check_eq("t1_valid", 32'(valid_o), 32'(exp_g[i]));
      check_eq("t1_ready", 32'(tx_ch_ready_o), 32'd1);
      check_eq("t1_data", data_o, 32'hD000_0000 + 32'(i));
      next_cyc();
    end
    tx_ch_valid_i = 1'b0;

    // 2: lock on requester 1 survives requester 3 arriving (RR pointer is at 3 here)
    req_i = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_eq("t2_req", 32'(tx_ch_req_o), 32'd1);
      check_eq("t2_addr", 32'(tx_ch_addr_o), 32'hA001);
      next_cyc();
    end
    req_i = 4'b1010;
    mid();
    check_eq("t2_lock_addr", 32'(tx_ch_addr_o), 32'hA001);
    next_cyc();
    tx_ch_gnt_i = 1'b1;
    mid();
    check_eq("t2_gnt1", 32'(gnt_o), 32'b0010);
    next_cyc();
    req_i = 4'b1000;
    mid();
    check_eq("t2_gnt3", 32'(gnt_o), 32'b1000);
    check_eq("t2_addr3", 32'(tx_ch_addr_o), 32'hA003);
    next_cyc();
    req_i         = '0;
    tx_ch_gnt_i   = 1'b0;
    tx_ch_valid_i = 1'b1;
    mid();
    check_eq("t2_rsp1", 32'(valid_o), 32'b0010);
    next_cyc();
    mid();
    check_eq("t2_rsp3", 32'(valid_o), 32'b1000);
    next_cyc();
    tx_ch_valid_i = 1'b0;

    // 3: fill to MAX_OUTST, request blocked, one pop frees one grant
    req_i       = 4'b1111;
    tx_ch_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check_eq("t3_gnt", 32'(gnt_o), 32'(1) << i);
      next_cyc();
    end
    mid();
    check_eq("t3_full_req", 32'(tx_ch_req_o), 32'd0);
    check_eq("t3_full_gnt", 32'(gnt_o), 32'd0);
    next_cyc();
    tx_ch_valid_i = 1'b1;
    mid();
    check_eq("t3_pop_valid", 32'(valid_o), 32'b0001);
    check_eq("t3_pop_req", 32'(tx_ch_req_o), 32'd0);
    next_cyc();
    tx_ch_valid_i = 1'b0;
    mid();
    check_eq("t3_regrant", 32'(gnt_o), 32'b0001);
    next_cyc();
    req_i       = '0;
    tx_ch_gnt_i = 1'b0;

    // 4: FIFO now holds 1,2,3,0; backpressure from requester 2
    tx_ch_valid_i = 1'b1;
    mid();
    check_eq("t4_rsp1", 32'(valid_o), 32'b0010);
    next_cyc();
    ready_i      = 4'b1011;
    tx_ch_data_i = 32'hDEAD_BEEF;
    mid();
    check_eq("t4_bp_ready", 32'(tx_ch_ready_o), 32'd0);
    check_eq("t4_bp_valid", 32'(valid_o), 32'b0100);
    next_cyc();
    mid();
    check_eq("t4_hold_valid", 32'(valid_o), 32'b0100);
    next_cyc();
    ready_i = 4'b1111;
    mid();
    check_eq("t4_rel_ready", 32'(tx_ch_ready_o), 32'd1);
    check_eq("t4_data", data_o, 32'hDEAD_BEEF);
    next_cyc();
    mid();
    check_eq("t4_rsp3", 32'(valid_o), 32'b1000);
    next_cyc();
    mid();
    check_eq("t4_rsp0", 32'(valid_o), 32'b0001);
    next_cyc();
    tx_ch_valid_i = 1'b0;

    // 5: response with FIFO empty is dropped and sets sticky error; clr clears it
    ready_i       = '0;
    tx_ch_valid_i = 1'b1;
    mid();
    check_eq("t5_ready", 32'(tx_ch_ready_o), 32'd1);
    check_eq("t5_valid", 32'(valid_o), 32'd0);
    check_eq("t5_err_pre", 32'(err_o), 32'd0);
    next_cyc();
    tx_ch_valid_i = 1'b0;
    mid();
    check_eq("t5_err_set", 32'(err_o), 32'd1);
    next_cyc();
    mid();
    check_eq("t5_err_sticky", 32'(err_o), 32'd1);
    next_cyc();
    clr_i = 1'b1;
    next_cyc();
    clr_i = 1'b0;
    mid();
    check_eq("t5_err_clr", 32'(err_o), 32'd0);
    next_cyc();

    // Flush in the same cycle as a grant: nothing recorded, later response is an error
    req_i       = 4'b0001;
    tx_ch_gnt_i = 1'b1;
    clr_i       = 1'b1;
    next_cyc();
    clr_i         = 1'b0;
    req_i         = '0;
    tx_ch_gnt_i   = 1'b0;
    tx_ch_valid_i = 1'b1;
    ready_i       = 4'b1111;
    mid();
    check_eq("fl_valid", 32'(valid_o), 32'd0);
    next_cyc();
    tx_ch_valid_i = 1'b0;
    mid();
    check_eq("fl_err", 32'(err_o), 32'd1);
    next_cyc();
    clr_i = 1'b1;
    next_cyc();
    clr_i = 1'b0;

    // 6: req 1011 held; priority build keeps granting 0, RR build rotates
`ifdef UDMA_STREAM_ARB_PRIO_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
`else
    exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0000};
`endif
    req_i       = 4'b1011;
    tx_ch_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_eq("t6_gnt_a", 32'(gnt_o), 32'(exp_g[i]));
      next_cyc();
    end
    req_i         = '0;
    tx_ch_gnt_i   = 1'b0;
    tx_ch_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_eq("t6_rsp", 32'(valid_o), 32'(exp_g[i]));
      next_cyc();
    end
    tx_ch_valid_i = 1'b0;
    exp_g = '{4'b0010, 4'b1000, 4'b0010, 4'b0000};
    req_i       = 4'b1010;
    tx_ch_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_eq("t6_gnt_b", 32'(gnt_o), 32'(exp_g[i]));
      next_cyc();
    end
    req_i       = '0;
    tx_ch_gnt_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
